// File: rtl/shifter_pkg.sv
// Shared constants for the pipelined barrel shifter.
//   MODE_* : fill-mode encodings carried with every word
//   DIR_*  : shift direction encodings
package shifter_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_ONES  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// One combinational step of the barrel shifter: shift by STEP when en=1.
//   data_in  : word entering this step
//   en       : this step's bit of the shift amount
//   dir      : DIR_LEFT / DIR_RIGHT
//   mode     : fill mode (logical, arithmetic, rotate, one-fill)
//   data_out : shifted word (data_in when en=0)
//   lost_out : OR of the bits pushed out by this step (0 for rotate)
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out,
  output logic             lost_out
);

  logic [STEP-1:0] out_l;   // bits leaving at the MSB end on a left shift
  logic [STEP-1:0] out_r;   // bits leaving at the LSB end on a right shift
  logic [STEP-1:0] fill_l;
  logic [STEP-1:0] fill_r;

  assign out_l = data_in[WIDTH-1 -: STEP];
  assign out_r = data_in[STEP-1:0];

  // Fill pattern for the vacated positions
  always_comb begin
    fill_l = '0;
    fill_r = '0;
    case (mode)
      MODE_ARITH: fill_r = {STEP{data_in[WIDTH-1]}};
      MODE_ROT: begin
        fill_l = out_l;
        fill_r = out_r;
      end
      MODE_ONES: begin
        fill_l = '1;
        fill_r = '1;
      end
      default: ;
    endcase
  end

  // Shift and lost-bit detection
  always_comb begin
    data_out = data_in;
    lost_out = 1'b0;
    if (en) begin
      if (dir == DIR_RIGHT) begin
        data_out = {fill_r, data_in[WIDTH-1:STEP]};
        lost_out = |out_r;
      end else begin
        data_out = {data_in[WIDTH-1-STEP:0], fill_l};
        lost_out = |out_l;
      end
    end
    // Rotation never discards bits
    if (mode == MODE_ROT) begin
      lost_out = 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready streams on both sides.
// Stage k shifts by 2^k when amt[k] is set; AMT_W stages give AMT_W cycles
// of latency at one word per cycle. The whole pipe advances or holds as one.
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : input handshake
//   in_data/amt/dir/mode  : word, shift amount, direction, fill mode
//   out_valid/out_ready   : output handshake
//   out_data/out_lost     : shifted word, any 1-bit discarded
//   busy                  : any stage holds a valid word
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost,
  output logic             busy
);

  // Stage registers
  logic [AMT_W-1:0] q_valid;
  logic [WIDTH-1:0] q_data [AMT_W];
  logic [AMT_W-1:0] q_amt  [AMT_W];
  logic             q_dir  [AMT_W];
  logic [1:0]       q_mode [AMT_W];
  logic             q_lost [AMT_W];

  // Per-stage inputs (from in_* for stage 0, else from the previous register)
  logic             st_valid [AMT_W];
  logic [WIDTH-1:0] st_data  [AMT_W];
  logic [AMT_W-1:0] st_amt   [AMT_W];
  logic             st_dir   [AMT_W];
  logic [1:0]       st_mode  [AMT_W];
  logic             st_lost  [AMT_W];

  // Per-stage combinational shift results
  logic [WIDTH-1:0] sh_data [AMT_W];
  logic             sh_lost [AMT_W];

  logic adv;

  // Whole pipe moves whenever the output slot is empty or being drained
  assign adv      = !q_valid[AMT_W-1] || out_ready;
  assign in_ready = adv;

  genvar k;
  generate
    for (k = 0; k < AMT_W; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign st_valid[k] = in_valid && in_ready;
        assign st_data[k]  = in_data;
        assign st_amt[k]   = in_amt;
        assign st_dir[k]   = in_dir;
        assign st_mode[k]  = in_mode;
        assign st_lost[k]  = 1'b0;
      end else begin : g_body
        assign st_valid[k] = q_valid[k-1];
        assign st_data[k]  = q_data[k-1];
        assign st_amt[k]   = q_amt[k-1];
        assign st_dir[k]   = q_dir[k-1];
        assign st_mode[k]  = q_mode[k-1];
        assign st_lost[k]  = q_lost[k-1];
      end

      shift_stage #(
        .WIDTH (WIDTH),
        .STEP  (32'd1 << k)
      ) u_stage (
        .data_in  (st_data[k]),
        .en       (st_amt[k][k]),
        .dir      (st_dir[k]),
        .mode     (st_mode[k]),
        .data_out (sh_data[k]),
        .lost_out (sh_lost[k])
      );
    end
  endgenerate

  // Stage registers: all load together on adv, all hold otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid <= '0;
      for (int i = 0; i < AMT_W; i++) begin
        q_data[i] <= '0;
        q_amt[i]  <= '0;
        q_dir[i]  <= 1'b0;
        q_mode[i] <= '0;
        q_lost[i] <= 1'b0;
      end
    end else if (adv) begin
      for (int i = 0; i < AMT_W; i++) begin
        q_valid[i] <= st_valid[i];
        q_data[i]  <= sh_data[i];
        q_amt[i]   <= st_amt[i];
        q_dir[i]   <= st_dir[i];
        q_mode[i]  <= st_mode[i];
        q_lost[i]  <= st_lost[i] | sh_lost[i];
      end
    end
  end

  assign out_valid = q_valid[AMT_W-1];
  assign out_data  = q_data[AMT_W-1];
  assign out_lost  = q_lost[AMT_W-1];
  assign busy      = |q_valid;

  // Control fields of the final stage have no consumer
  logic unused_tail;
  assign unused_tail = ^{q_amt[AMT_W-1], q_dir[AMT_W-1], q_mode[AMT_W-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=8).
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_lost;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Stream tables: stream 0 = 01 logical left, stream 1 = 0F logical right, amt = index
  logic [7:0] s_in  [2]    = '{8'h01, 8'h0F};
  logic       s_dir [2]    = '{1'b0, 1'b1};
  logic [7:0] s_exp [2][6] = '{'{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20},
                               '{8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00}};
  logic       s_lst [2][6] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                               '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}};

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lost  (out_lost),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated word: checks acceptance, latency, result and lost flag
  task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] a,
                          input logic dir, input logic [1:0] m,
                          input logic [7:0] ed, input logic el);
    int lat;
    lat = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_dir    = dir;
    in_mode   = m;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_data"}, 32'(out_data), 32'(ed));
    check({tag, "_lost"}, 32'(out_lost), 32'(el));
  endtask

  // Six back-to-back words with an optional output stall
  task automatic run_stream(input int s, input int stall_start, input int stall_len);
    int sent;
    int rcv;
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 60 && rcv < 6; c++) begin
      @(negedge clk);
      out_ready = !(stall_len > 0 && c >= stall_start && c < stall_start + stall_len);
      in_valid  = (sent < 6);
      in_data   = s_in[s];
      in_amt    = 3'(sent);
      in_dir    = s_dir[s];
      in_mode   = MODE_LOGIC;
      #1;
      if (!out_ready) begin
        check($sformatf("s%0d_stall_rdy", s), 32'(in_ready), 32'd0);
        check($sformatf("s%0d_stall_vld", s), 32'(out_valid), 32'd1);
        check($sformatf("s%0d_stall_hold", s), 32'(out_data), 32'(s_exp[s][rcv]));
      end
      if (out_valid && out_ready) begin
        check($sformatf("s%0d_w%0d_data", s, rcv), 32'(out_data), 32'(s_exp[s][rcv]));
        check($sformatf("s%0d_w%0d_lost", s, rcv), 32'(out_lost), 32'(s_lst[s][rcv]));
        if (stall_len == 0) check($sformatf("s%0d_w%0d_cyc", s, rcv), 32'(c), 32'(3 + rcv));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    check($sformatf("s%0d_count", s), 32'(rcv), 32'd6);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check($sformatf("s%0d_drain_busy", s), 32'(busy), 32'd0);
    check($sformatf("s%0d_drain_vld", s), 32'(out_valid), 32'd0);
  endtask

  initial begin
    int ghost;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    in_mode   = '0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_vld",  32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data),  32'd0);
    check("rst_lost", 32'(out_lost),  32'd0);
    check("rst_busy", 32'(busy),      32'd0);
    check("rst_rdy",  32'(in_ready),  32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors
    send_one("lsl3",   8'h85, 3'd3, DIR_LEFT,  MODE_LOGIC, 8'h28, 1'b1);
    send_one("asr3",   8'h85, 3'd3, DIR_RIGHT, MODE_ARITH, 8'hF0, 1'b1);
    send_one("lsr3",   8'h85, 3'd3, DIR_RIGHT, MODE_LOGIC, 8'h10, 1'b1);
    send_one("ror3",   8'h85, 3'd3, DIR_RIGHT, MODE_ROT,   8'hB0, 1'b0);
    send_one("ofl2",   8'h01, 3'd2, DIR_LEFT,  MODE_ONES,  8'h07, 1'b0);
    send_one("asl3",   8'h85, 3'd3, DIR_LEFT,  MODE_ARITH, 8'h28, 1'b1);
    send_one("ofr3",   8'h85, 3'd3, DIR_RIGHT, MODE_ONES,  8'hF0, 1'b1);
    send_one("rol3",   8'h85, 3'd3, DIR_LEFT,  MODE_ROT,   8'h2C, 1'b0);
    send_one("rol7",   8'h81, 3'd7, DIR_LEFT,  MODE_ROT,   8'hC0, 1'b0);
    send_one("z_log",  8'hA5, 3'd0, DIR_LEFT,  MODE_LOGIC, 8'hA5, 1'b0);
    send_one("z_ari",  8'hA5, 3'd0, DIR_RIGHT, MODE_ARITH, 8'hA5, 1'b0);
    send_one("z_rot",  8'hA5, 3'd0, DIR_RIGHT, MODE_ROT,   8'hA5, 1'b0);
    send_one("z_one",  8'hA5, 3'd0, DIR_LEFT,  MODE_ONES,  8'hA5, 1'b0);
    send_one("lsl7",   8'hA5, 3'd7, DIR_LEFT,  MODE_LOGIC, 8'h80, 1'b1);
    send_one("asr7",   8'h80, 3'd7, DIR_RIGHT, MODE_ARITH, 8'hFF, 1'b0);

    // Streaming: full throughput, then a 5-cycle output stall
    run_stream(0, 0, 0);
    run_stream(1, 4, 5);

    // Reset with words in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_amt    = 3'd1;
    in_dir    = DIR_LEFT;
    in_mode   = MODE_LOGIC;
    @(negedge clk);
    in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_vld", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_vld",  32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy),      32'd0);
    check("mid_rst_data", 32'(out_data),  32'd0);
    check("mid_rst_lost", 32'(out_lost),  32'd0);
    check("mid_rst_rdy",  32'(in_ready),  32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (out_valid || busy) ghost++;
    end
    check("post_rst_ghost", 32'(ghost), 32'd0);
    send_one("post_rst", 8'h85, 3'd3, DIR_RIGHT, MODE_ROT, 8'hB0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
